// File: rtl/decode.sv
// Decode stage of the five-stage RV32I pipeline. Drives the register-file
// read addresses straight from the fetched instruction. Decodes the
// instruction into ALU controls, memory/system strobes and an immediate.
// Registers the result, with the sampled operands, into the decode/execute
// pipeline register.
module decode #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            invalidate,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] next_pc_in,
  input  logic [XLEN-1:0] instr_in,
  input  logic            valid_in,
  output logic [4:0]      rs1_address,
  output logic [4:0]      rs2_address,
  output logic            uses_rs1,
  output logic            uses_rs2,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] next_pc_out,
  output logic [XLEN-1:0] rs1_data_out,
  output logic [XLEN-1:0] rs2_data_out,
  output logic [4:0]      rd_address_out,
  output logic [XLEN-1:0] imm_out,
  output logic [3:0]      alu_function_out,
  output logic            alu_sel_a_out,
  output logic            alu_sel_b_out,
  output logic            branch_out,
  output logic            jump_out,
  output logic            load_out,
  output logic            store_out,
  output logic [2:0]      funct3_out,
  output logic            csr_out,
  output logic            ecall_out,
  output logic            ebreak_out,
  output logic            mret_out,
  output logic            illegal_out,
  output logic            valid_out
);

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0f;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];

  logic [31:0] imm_d;
  logic [3:0]  aluFunction_d;
  logic        selA_d, selB_d;
  logic        branch_d, jump_d, load_d, store_d;
  logic        csr_d, ecall_d, ebreak_d, mret_d, illegal_d;
  logic        writesRd, readsRs1, readsRs2, isLui;
  logic [4:0]  rdAddress_d;
  logic        live;

  logic [31:0] pc_q, nextPc_q, rs1Data_q, rs2Data_q, imm_q;
  logic [4:0]  rdAddress_q;
  logic [3:0]  aluFunction_q;
  logic [2:0]  funct3_q;
  logic        selA_q, selB_q, branch_q, jump_q, load_q, store_q;
  logic        csr_q, ecall_q, ebreak_q, mret_q, illegal_q, valid_q;

  // funct3 selects the ALU operation for OP/OP-IMM; alt picks SUB/SRA.
  function automatic logic [3:0] aluFromFunct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Decode the opcode into controls and immediate; an illegal encoding
  // clears every strobe and register use so only illegal survives.
  always_comb begin
    imm_d         = '0;
    aluFunction_d = ALU_ADD;
    selA_d        = 1'b0;
    selB_d        = 1'b0;
    branch_d      = 1'b0;
    jump_d        = 1'b0;
    load_d        = 1'b0;
    store_d       = 1'b0;
    csr_d         = 1'b0;
    ecall_d       = 1'b0;
    ebreak_d      = 1'b0;
    mret_d        = 1'b0;
    illegal_d     = 1'b0;
    writesRd      = 1'b0;
    readsRs1      = 1'b0;
    readsRs2      = 1'b0;
    isLui         = 1'b0;
    if (instr_in[1:0] != 2'b11) begin
      illegal_d = 1'b1;
    end else begin
      case (opcode)
        OP_LUI: begin
          isLui    = 1'b1;
          imm_d    = {instr_in[31:12], 12'b0};
          selB_d   = 1'b1;
          writesRd = 1'b1;
        end
        OP_AUIPC: begin
          imm_d    = {instr_in[31:12], 12'b0};
          selA_d   = 1'b1;
          selB_d   = 1'b1;
          writesRd = 1'b1;
        end
        OP_JAL: begin
          imm_d    = {{12{instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
          selA_d   = 1'b1;
          selB_d   = 1'b1;
          jump_d   = 1'b1;
          writesRd = 1'b1;
        end
        OP_JALR: begin
          imm_d    = {{20{instr_in[31]}}, instr_in[31:20]};
          selB_d   = 1'b1;
          jump_d   = 1'b1;
          writesRd = 1'b1;
          readsRs1 = 1'b1;
        end
        OP_BRANCH: begin
          imm_d         = {{20{instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
          aluFunction_d = ALU_SUB;
          readsRs1      = 1'b1;
          readsRs2      = 1'b1;
          if (funct3 == 3'd2 || funct3 == 3'd3) illegal_d = 1'b1;
          else                                  branch_d  = 1'b1;
        end
        OP_LOAD: begin
          imm_d    = {{20{instr_in[31]}}, instr_in[31:20]};
          selB_d   = 1'b1;
          writesRd = 1'b1;
          readsRs1 = 1'b1;
          if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) illegal_d = 1'b1;
          else                                                    load_d    = 1'b1;
        end
        OP_STORE: begin
          imm_d    = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
          selB_d   = 1'b1;
          readsRs1 = 1'b1;
          readsRs2 = 1'b1;
          if (funct3 >= 3'd3) illegal_d = 1'b1;
          else                store_d   = 1'b1;
        end
        OP_IMM: begin
          imm_d         = {{20{instr_in[31]}}, instr_in[31:20]};
          selB_d        = 1'b1;
          writesRd      = 1'b1;
          readsRs1      = 1'b1;
          aluFunction_d = aluFromFunct3(funct3, (funct3 == 3'd5) && funct7[5]);
          if (funct3 == 3'd1 && funct7 != 7'h00) illegal_d = 1'b1;
          if (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20) illegal_d = 1'b1;
        end
        OP_REG: begin
          writesRd = 1'b1;
          readsRs1 = 1'b1;
          readsRs2 = 1'b1;
          if (funct7 == 7'h00 ||
              (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)))
            aluFunction_d = aluFromFunct3(funct3, funct7[5]);
          else
            illegal_d = 1'b1;
        end
        OP_FENCE: begin
        end
        OP_SYSTEM: begin
          imm_d = {{20{instr_in[31]}}, instr_in[31:20]};
          if (funct3 == 3'd0) begin
            if (instr_in == 32'h00000073)      ecall_d   = 1'b1;
            else if (instr_in == 32'h00100073) ebreak_d  = 1'b1;
            else if (instr_in == 32'h30200073) mret_d    = 1'b1;
            else                               illegal_d = 1'b1;
          end else if (funct3 == 3'd4) begin
            illegal_d = 1'b1;
          end else begin
            csr_d    = 1'b1;
            writesRd = 1'b1;
            readsRs1 = ~funct3[2];
          end
        end
        default: illegal_d = 1'b1;
      endcase
    end
    if (illegal_d) begin
      branch_d = 1'b0;
      jump_d   = 1'b0;
      load_d   = 1'b0;
      store_d  = 1'b0;
      csr_d    = 1'b0;
      ecall_d  = 1'b0;
      ebreak_d = 1'b0;
      mret_d   = 1'b0;
      writesRd = 1'b0;
      readsRs1 = 1'b0;
      readsRs2 = 1'b0;
    end
  end

  assign rdAddress_d = writesRd ? instr_in[11:7] : 5'd0;
  assign rs1_address = isLui ? 5'd0 : instr_in[19:15];
  assign rs2_address = instr_in[24:20];
  assign uses_rs1    = valid_in & readsRs1;
  assign uses_rs2    = valid_in & readsRs2;
  assign live        = valid_in & ~invalidate;

  // Decode/execute register: hold on stall, otherwise capture and squash
  // the control strobes when the incoming slot is empty or flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= '0;
      nextPc_q      <= '0;
      rs1Data_q     <= '0;
      rs2Data_q     <= '0;
      imm_q         <= '0;
      rdAddress_q   <= '0;
      aluFunction_q <= '0;
      funct3_q      <= '0;
      selA_q        <= 1'b0;
      selB_q        <= 1'b0;
      branch_q      <= 1'b0;
      jump_q        <= 1'b0;
      load_q        <= 1'b0;
      store_q       <= 1'b0;
      csr_q         <= 1'b0;
      ecall_q       <= 1'b0;
      ebreak_q      <= 1'b0;
      mret_q        <= 1'b0;
      illegal_q     <= 1'b0;
      valid_q       <= 1'b0;
    end else if (!stall) begin
      pc_q          <= pc_in;
      nextPc_q      <= next_pc_in;
      rs1Data_q     <= rs1_data_in;
      rs2Data_q     <= rs2_data_in;
      imm_q         <= imm_d;
      aluFunction_q <= aluFunction_d;
      funct3_q      <= funct3;
      selA_q        <= selA_d;
      selB_q        <= selB_d;
      rdAddress_q   <= live ? rdAddress_d : 5'd0;
      branch_q      <= live & branch_d;
      jump_q        <= live & jump_d;
      load_q        <= live & load_d;
      store_q       <= live & store_d;
      csr_q         <= live & csr_d;
      ecall_q       <= live & ecall_d;
      ebreak_q      <= live & ebreak_d;
      mret_q        <= live & mret_d;
      illegal_q     <= live & illegal_d;
      valid_q       <= live;
    end
  end

  assign pc_out           = pc_q;
  assign next_pc_out      = nextPc_q;
  assign rs1_data_out     = rs1Data_q;
  assign rs2_data_out     = rs2Data_q;
  assign imm_out          = imm_q;
  assign rd_address_out   = rdAddress_q;
  assign alu_function_out = aluFunction_q;
  assign alu_sel_a_out    = selA_q;
  assign alu_sel_b_out    = selB_q;
  assign funct3_out       = funct3_q;
  assign branch_out       = branch_q;
  assign jump_out         = jump_q;
  assign load_out         = load_q;
  assign store_out        = store_q;
  assign csr_out          = csr_q;
  assign ecall_out        = ecall_q;
  assign ebreak_out       = ebreak_q;
  assign mret_out         = mret_q;
  assign illegal_out      = illegal_q;
  assign valid_out        = valid_q;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for the decode stage: directed scenarios followed by
// randomized instruction streams checked against a behavioural model.
module tb_decode;

  logic        clk = 1'b0;
  logic        reset, stall, invalidate, valid_in;
  logic [31:0] pc_in, next_pc_in, instr_in, rs1_data_in, rs2_data_in;
  logic [4:0]  rs1_address, rs2_address, rd_address_out;
  logic        uses_rs1, uses_rs2;
  logic [31:0] pc_out, next_pc_out, rs1_data_out, rs2_data_out, imm_out;
  logic [3:0]  alu_function_out;
  logic [2:0]  funct3_out;
  logic        alu_sel_a_out, alu_sel_b_out, branch_out, jump_out, load_out, store_out;
  logic        csr_out, ecall_out, ebreak_out, mret_out, illegal_out, valid_out;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] regs [32];

  localparam int ALU_LUT [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  typedef struct {
    bit ill, br, jp, ld, st, csr, ec, eb, mr;
    bit [4:0] rd, rs1a, rs2a;
    bit [31:0] imm;
    bit immDef;
    bit [3:0] alu;
    bit aluDef;
    bit selA, selB, selDef;
    bit u1, u2;
  } exp_t;

  decode #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .invalidate(invalidate),
    .pc_in(pc_in), .next_pc_in(next_pc_in), .instr_in(instr_in), .valid_in(valid_in),
    .rs1_address(rs1_address), .rs2_address(rs2_address),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .pc_out(pc_out), .next_pc_out(next_pc_out),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
    .rd_address_out(rd_address_out), .imm_out(imm_out),
    .alu_function_out(alu_function_out), .alu_sel_a_out(alu_sel_a_out),
    .alu_sel_b_out(alu_sel_b_out), .branch_out(branch_out), .jump_out(jump_out),
    .load_out(load_out), .store_out(store_out), .funct3_out(funct3_out),
    .csr_out(csr_out), .ecall_out(ecall_out), .ebreak_out(ebreak_out),
    .mret_out(mret_out), .illegal_out(illegal_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  // Reference decode built from the instruction-set rules with arithmetic.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int s, op, f3, f7, iI, iS, iB, iJ;
    bit [4:0] rdf;
    e = '{default: 0};
    s  = int'(w);
    op = int'(w & 32'h7f);
    f3 = int'((w >> 12) & 7);
    f7 = int'((w >> 25) & 32'h7f);
    rdf = 5'((w >> 7) & 31);
    e.rs1a = 5'((w >> 15) & 31);
    e.rs2a = 5'((w >> 20) & 31);
    iI = s >>> 20;
    iS = (s >>> 25) * 32 + int'((w >> 7) & 31);
    iB = (s >>> 31) * 4096 + int'((w >> 7) & 1) * 2048 + int'((w >> 25) & 63) * 32 + int'((w >> 8) & 15) * 2;
    iJ = (s >>> 31) * 1048576 + int'((w >> 12) & 255) * 4096 + int'((w >> 20) & 1) * 2048 + int'((w >> 21) & 1023) * 2;
    if ((w & 3) != 3) e.ill = 1;
    else case (op)
      'h37: begin e.rd = rdf; e.imm = w & 32'hFFFFF000; e.immDef = 1; e.aluDef = 1;
                  e.selB = 1; e.selDef = 1; e.rs1a = 0; end
      'h17: begin e.rd = rdf; e.imm = w & 32'hFFFFF000; e.immDef = 1; e.aluDef = 1;
                  e.selA = 1; e.selB = 1; e.selDef = 1; end
      'h6f: begin e.jp = 1; e.rd = rdf; e.imm = 32'(iJ); e.immDef = 1; e.aluDef = 1;
                  e.selA = 1; e.selB = 1; e.selDef = 1; end
      'h67: begin e.jp = 1; e.rd = rdf; e.imm = 32'(iI); e.immDef = 1; e.aluDef = 1;
                  e.selB = 1; e.selDef = 1; e.u1 = 1; end
      'h63: if (f3 == 2 || f3 == 3) e.ill = 1;
            else begin e.br = 1; e.imm = 32'(iB); e.immDef = 1; e.alu = 1; e.aluDef = 1;
                       e.selDef = 1; e.u1 = 1; e.u2 = 1; end
      'h03: if (f3 == 3 || f3 >= 6) e.ill = 1;
            else begin e.ld = 1; e.rd = rdf; e.imm = 32'(iI); e.immDef = 1; e.aluDef = 1;
                       e.selB = 1; e.selDef = 1; e.u1 = 1; end
      'h23: if (f3 >= 3) e.ill = 1;
            else begin e.st = 1; e.imm = 32'(iS); e.immDef = 1; e.aluDef = 1;
                       e.selB = 1; e.selDef = 1; e.u1 = 1; e.u2 = 1; end
      'h13: begin
        e.rd = rdf; e.imm = 32'(iI); e.immDef = 1; e.aluDef = 1; e.selB = 1; e.selDef = 1; e.u1 = 1;
        e.alu = 4'(ALU_LUT[f3]);
        if (f3 == 1 && f7 != 0) e.ill = 1;
        if (f3 == 5) begin
          if (f7 == 'h20) e.alu = 7;
          else if (f7 != 0) e.ill = 1;
        end
      end
      'h33: begin
        e.rd = rdf; e.immDef = 1; e.aluDef = 1; e.selDef = 1; e.u1 = 1; e.u2 = 1;
        if (f7 == 0) e.alu = 4'(ALU_LUT[f3]);
        else if (f7 == 'h20 && f3 == 0) e.alu = 1;
        else if (f7 == 'h20 && f3 == 5) e.alu = 7;
        else e.ill = 1;
      end
      'h0f: ;
      'h73: begin
        if (f3 == 0) begin
          if (w == 32'h00000073) e.ec = 1;
          else if (w == 32'h00100073) e.eb = 1;
          else if (w == 32'h30200073) e.mr = 1;
          else e.ill = 1;
        end else if (f3 == 4) e.ill = 1;
        else begin e.csr = 1; e.rd = rdf; e.imm = 32'(iI); e.immDef = 1; e.u1 = (f3 <= 3); end
      end
      default: e.ill = 1;
    endcase
    if (e.ill) begin
      e.br = 0; e.jp = 0; e.ld = 0; e.st = 0; e.csr = 0; e.ec = 0; e.eb = 0; e.mr = 0;
      e.rd = 0; e.u1 = 0; e.u2 = 0; e.immDef = 0; e.aluDef = 0; e.selDef = 0;
    end
    return e;
  endfunction

  // Instruction generator biased toward real opcodes and legal/alt funct7.
  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    int pick;
    w = $urandom;
    pick = $urandom_range(0, 15);
    if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    case (pick)
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h6f;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h03;
      6: w[6:0] = 7'h23;
      7, 8: w[6:0] = 7'h13;
      9, 10: w[6:0] = 7'h33;
      11: w[6:0] = 7'h0f;
      12: w[6:0] = 7'h73;
      13: case ($urandom_range(0, 2))
            0: w = 32'h00000073;
            1: w = 32'h00100073;
            default: w = 32'h30200073;
          endcase
      14: ;
      default: w[1:0] = 2'b11;
    endcase
    return w;
  endfunction

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc, input logic vin,
                               input logic st, input logic inv, input logic [31:0] r1, input logic [31:0] r2);
    instr_in = instr; pc_in = pc; next_pc_in = pc + 32'd4; valid_in = vin;
    stall = st; invalidate = inv; rs1_data_in = r1; rs2_data_in = r2;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(32'h00510093, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (valid_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %0b want 0", valid_out); end
    vectors++;
    if ({illegal_out, branch_out, jump_out, rd_address_out, imm_out, pc_out} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_fields got ill=%0b rd=%0d imm=%h pc=%h want 0", illegal_out, rd_address_out, imm_out, pc_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_addi();
    applyStimulus(32'h00510093, 32'h40, 1'b1, 1'b0, 1'b0, 32'd7, 32'd3);
    #1;
    vectors++;
    if (rs1_address !== 5'd2) begin miscompares++; $display("[TB] FAIL addi_rs1_address got %0d want 2", rs1_address); end
    tick();
    vectors++;
    if (valid_out !== 1'b1 || rd_address_out !== 5'd1 || imm_out !== 32'd5) begin
      miscompares++;
      $display("[TB] FAIL addi_fields got v=%0b rd=%0d imm=%h want v=1 rd=1 imm=5", valid_out, rd_address_out, imm_out);
    end
    vectors++;
    if (alu_function_out !== 4'd0 || alu_sel_b_out !== 1'b1 || rs1_data_out !== 32'd7) begin
      miscompares++;
      $display("[TB] FAIL addi_alu got alu=%0d selb=%0b rs1=%h want alu=0 selb=1 rs1=7", alu_function_out, alu_sel_b_out, rs1_data_out);
    end
  endtask

  task automatic test_branch();
    applyStimulus(32'hFE000EE3, 32'h100, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    vectors++;
    if (branch_out !== 1'b1 || imm_out !== 32'hFFFFFFFC || rd_address_out !== 5'd0 ||
        funct3_out !== 3'd0 || alu_function_out !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL beq got br=%0b imm=%h rd=%0d f3=%0d alu=%0d want br=1 imm=fffffffc rd=0 f3=0 alu=1",
               branch_out, imm_out, rd_address_out, funct3_out, alu_function_out);
    end
  endtask

  task automatic test_lui();
    applyStimulus(32'h123452B7, 32'h200, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    vectors++;
    if (uses_rs1 !== 1'b0 || rs1_address !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL lui_rs1 got uses=%0b addr=%0d want uses=0 addr=0", uses_rs1, rs1_address);
    end
    tick();
    vectors++;
    if (imm_out !== 32'h12345000 || rd_address_out !== 5'd5) begin
      miscompares++;
      $display("[TB] FAIL lui_fields got imm=%h rd=%0d want imm=12345000 rd=5", imm_out, rd_address_out);
    end
  endtask

  task automatic test_illegal_ecall();
    applyStimulus(32'h00000000, 32'h300, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    vectors++;
    if (illegal_out !== 1'b1 || valid_out !== 1'b1 || rd_address_out !== 5'd0 ||
        {branch_out, jump_out, load_out, store_out, csr_out, ecall_out, ebreak_out, mret_out} !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL illegal_zero got ill=%0b v=%0b rd=%0d want ill=1 v=1 rd=0 strobes 0", illegal_out, valid_out, rd_address_out);
    end
    applyStimulus(32'h00000073, 32'h304, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    vectors++;
    if (ecall_out !== 1'b1 || illegal_out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ecall got ecall=%0b ill=%0b want ecall=1 ill=0", ecall_out, illegal_out);
    end
  endtask

  task automatic test_hold_flush();
    applyStimulus(32'h00510093, 32'h400, 1'b1, 1'b0, 1'b0, 32'd7, 32'd9);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(randInstr(), $urandom, 1'b1, 1'b1, 1'b0, $urandom, $urandom);
      tick();
      vectors++;
      if (valid_out !== 1'b1 || rd_address_out !== 5'd1 || imm_out !== 32'd5 ||
          rs1_data_out !== 32'd7 || pc_out !== 32'h400) begin
        miscompares++;
        $display("[TB] FAIL stall_hold got v=%0b rd=%0d imm=%h rs1=%h pc=%h want v=1 rd=1 imm=5 rs1=7 pc=400",
                 valid_out, rd_address_out, imm_out, rs1_data_out, pc_out);
      end
    end
    applyStimulus(32'hFE000EE3, 32'h500, 1'b1, 1'b1, 1'b1, 32'd0, 32'd0);
    tick();
    vectors++;
    if (valid_out !== 1'b1 || rd_address_out !== 5'd1) begin
      miscompares++;
      $display("[TB] FAIL stall_over_flush got v=%0b rd=%0d want v=1 rd=1", valid_out, rd_address_out);
    end
    applyStimulus(32'hFE000EE3, 32'h500, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
    tick();
    vectors++;
    if (valid_out !== 1'b0 || rd_address_out !== 5'd0 ||
        {branch_out, jump_out, load_out, store_out, csr_out, ecall_out, ebreak_out, mret_out, illegal_out} !== 9'h000) begin
      miscompares++;
      $display("[TB] FAIL flush got v=%0b rd=%0d br=%0b want v=0 rd=0 strobes 0", valid_out, rd_address_out, branch_out);
    end
    applyStimulus(32'h00510093, 32'h600, 1'b1, 1'b1, 1'b1, 32'd0, 32'd0);
    tick();
    vectors++;
    if (valid_out !== 1'b0 || rd_address_out !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL flush_hold got v=%0b rd=%0d want v=0 rd=0", valid_out, rd_address_out);
    end
  endtask

  task automatic test_random();
    exp_t e, h;
    logic [31:0] instr, pc, r1, r2, hPc, hR1, hR2;
    logic [2:0] hF3;
    logic vin, st, inv, hValid;
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    tick();
    h = '{default: 0};
    hValid = 1'b0; hPc = '0; hR1 = '0; hR2 = '0; hF3 = '0;
    for (int i = 0; i < 500; i++) begin
      instr = randInstr();
      e = model(instr);
      pc = $urandom & 32'hFFFFFFFC;
      vin = ($urandom_range(0, 9) != 0);
      st  = ($urandom_range(0, 7) == 0);
      inv = ($urandom_range(0, 9) == 0);
      r1 = regs[e.rs1a];
      r2 = regs[e.rs2a];
      applyStimulus(instr, pc, vin, st, inv, r1, r2);
      #1;
      vectors++;
      if ({rs1_address, rs2_address, uses_rs1, uses_rs2} !== {e.rs1a, e.rs2a, vin & e.u1, vin & e.u2}) begin
        miscompares++;
        $display("[TB] FAIL rand_comb instr=%h got a1=%0d a2=%0d u1=%0b u2=%0b want a1=%0d a2=%0d u1=%0b u2=%0b",
                 instr, rs1_address, rs2_address, uses_rs1, uses_rs2, e.rs1a, e.rs2a, vin & e.u1, vin & e.u2);
      end
      tick();
      if (!st) begin
        hValid = vin && !inv;
        if (hValid) begin h = e; hPc = pc; hR1 = r1; hR2 = r2; hF3 = instr[14:12]; end
        else h = '{default: 0};
      end
      vectors++;
      if (valid_out !== hValid || rd_address_out !== h.rd ||
          {illegal_out, branch_out, jump_out, load_out, store_out, csr_out, ecall_out, ebreak_out, mret_out} !==
          {h.ill, h.br, h.jp, h.ld, h.st, h.csr, h.ec, h.eb, h.mr}) begin
        miscompares++;
        $display("[TB] FAIL rand_ctrl instr=%h got v=%0b rd=%0d strobes=%b want v=%0b rd=%0d strobes=%b", instr,
                 valid_out, rd_address_out,
                 {illegal_out, branch_out, jump_out, load_out, store_out, csr_out, ecall_out, ebreak_out, mret_out},
                 hValid, h.rd, {h.ill, h.br, h.jp, h.ld, h.st, h.csr, h.ec, h.eb, h.mr});
      end
      if (hValid) begin
        vectors++;
        if (pc_out !== hPc || next_pc_out !== hPc + 32'd4 || rs1_data_out !== hR1 ||
            rs2_data_out !== hR2 || funct3_out !== hF3) begin
          miscompares++;
          $display("[TB] FAIL rand_data got pc=%h npc=%h r1=%h r2=%h f3=%0d want pc=%h npc=%h r1=%h r2=%h f3=%0d",
                   pc_out, next_pc_out, rs1_data_out, rs2_data_out, funct3_out, hPc, hPc + 32'd4, hR1, hR2, hF3);
        end
        vectors++;
        if ((h.immDef && imm_out !== h.imm) || (h.aluDef && alu_function_out !== h.alu) ||
            (h.selDef && {alu_sel_a_out, alu_sel_b_out} !== {h.selA, h.selB})) begin
          miscompares++;
          $display("[TB] FAIL rand_decode got imm=%h alu=%0d sel=%b%b want imm=%h alu=%0d sel=%b%b",
                   imm_out, alu_function_out, alu_sel_a_out, alu_sel_b_out, h.imm, h.alu, h.selA, h.selB);
        end
      end
    end
  endtask

  task automatic test_reset_async();
    applyStimulus(32'h00510093, 32'h700, 1'b1, 1'b0, 1'b0, 32'd7, 32'd1);
    tick();
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (valid_out !== 1'b0 || rd_address_out !== 5'd0 || imm_out !== 32'd0 ||
        pc_out !== 32'd0 || rs1_data_out !== 32'd0 || alu_sel_b_out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset got v=%0b rd=%0d imm=%h pc=%h rs1=%h want all 0",
               valid_out, rd_address_out, imm_out, pc_out, rs1_data_out);
    end
    #1 reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
    test_reset();
    test_addi();
    test_branch();
    test_lui();
    test_illegal_ecall();
    test_hold_flush();
    test_random();
    test_reset_async();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
